// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed
// gate window of GATE_CYCLES clk cycles. It runs either one measurement per
// start request or back-to-back windows while cont is held high.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq_out,
  output logic             ovf
);

  // The gate counter is sized from the window length, independent of the
  // result width, so a narrow result can still use a long window.
  localparam int               GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat_flag;

  logic              sig_p1;
  logic              sig_p2;
  logic              sig_p3;
  logic              edge_p2;

  // Saturating increment of the edge counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             inc);
    return (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  // An edge arriving while the counter is already at its ceiling is lost.
  function automatic logic sat_hit(input logic [CNT_W-1:0] c,
                                   input logic             inc);
    return inc && (c == CNT_MAX);
  endfunction

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_p1 <= 1'b0;
      sig_p2 <= 1'b0;
      sig_p3 <= 1'b0;
    end else begin
      sig_p1 <= sig_in;
      sig_p2 <= sig_p1;
      sig_p3 <= sig_p2;
    end
  end

  // Stage p2/p3 boundary: one-cycle pulse per synchronized rising edge.
  assign edge_p2 = sig_p2 & ~sig_p3;

  // Measurement sequencer: gate timing, edge accumulation and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      freq_out <= '0;
      ovf      <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= MEASURE;
            busy     <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
          end
        end
        MEASURE: begin
          edge_cnt <= sat_inc(edge_cnt, edge_p2);
          sat_flag <= sat_flag | sat_hit(edge_cnt, edge_p2);
          if (gate_cnt == GATE_LAST) begin
            // The final cycle's edge is folded directly into the result.
            state    <= DONE;
            freq_out <= sat_inc(edge_cnt, edge_p2);
            ovf      <= sat_flag | sat_hit(edge_cnt, edge_p2);
            valid    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
          end
        end
        DONE: begin
          // Dead cycle: edges here are dropped and the next window starts clean.
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat_flag <= 1'b0;
          if (cont) begin
            state <= MEASURE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
